// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// shared_reg_arbiter : round-robin arbiter owning one shared DW-bit register
// Revision 1.0
// ============================================================================
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    wr_en,
  input  logic [N_REQ*DW-1:0] wr_data,
  output logic [N_REQ-1:0]    grant,
  output logic [DW-1:0]       q,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DW-1:0]     q_q, q_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     scan_idx;
  logic              pick_found;
  logic [DW-1:0]     wr_word [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign wr_word[gi] = wr_data[gi*DW +: DW];
  end

  // First active request scanning upward from the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    q_d     = q_q;

    // The holder's write lands even on its final grant cycle.
    if (state_q == GRANT && wr_en[owner_q]) begin
      q_d = wr_word[owner_q];
    end

    case (state_q)
      IDLE, GAP: begin
        grant_d = '0;
        if (pick_found) begin
          state_d           = GRANT;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          hold_d            = HW'(1);
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
          state_d = GAP;
          grant_d = '0;
          hold_d  = '0;
          ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;
  assign q     = q_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shared_reg_arbiter : vector table, corner sequences and random model check
// Revision 1.0
// ============================================================================
module tb_shared_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  grant;
  logic [7:0]  q;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the register, for how long, and whose turn is next.
  int         m_holder;
  int         m_cnt;
  int         m_ptr;
  logic [7:0] m_q;

  shared_reg_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .grant   (grant),
    .q       (q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    int i;
    logic found;
    if (rst) begin
      m_holder = -1;
      m_cnt    = 0;
      m_ptr    = 0;
      m_q      = 8'h00;
    end else if (m_holder >= 0) begin
      if (wr_en[m_holder[1:0]]) m_q = 8'(wr_data >> (8 * m_holder));
      if (!req[m_holder[1:0]] || m_cnt == MAX_HOLD) begin
        m_ptr    = (m_holder + 1) % N_REQ;
        m_holder = -1;
        m_cnt    = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        i = (m_ptr + k) % N_REQ;
        if (!found && req[i[1:0]]) begin
          found    = 1'b1;
          m_holder = i;
          m_cnt    = 1;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1; req = '0; wr_en = '0; wr_data = '0;

    // Reset with noisy inputs, single requester write, foreign write, timeout write.
    tbl[0]  = '{1'b1, 4'($urandom), 4'($urandom), 32'($urandom), 4'b0000, 8'h00};
    tbl[1]  = '{1'b1, 4'($urandom), 4'($urandom), 32'($urandom), 4'b0000, 8'h00};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 8'h00};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0100, 32'h003C_0000, 4'b0001, 8'hA5};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 8'hA5};
    tbl[6]  = '{1'b0, 4'b0001, 4'b0001, 32'h0000_00EE, 4'b0000, 8'hEE};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0001, 32'h0000_0077, 4'b0001, 8'hEE};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0001, 32'h0000_0099, 4'b0000, 8'h99};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h99};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h99};

    #2;
    for (int v = 0; v < 11; v++) begin
      rst = tbl[v].rst; req = tbl[v].req; wr_en = tbl[v].wr_en; wr_data = tbl[v].wr_data;
      tick();
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(tbl[v].exp_grant));
      check($sformatf("vec%0d_q", v), 32'(q), 32'(tbl[v].exp_q));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(|tbl[v].exp_grant));
    end

    // Full contention: 4-cycle grants rotating 0..3 with one idle cycle between.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1111; wr_en = '0;
    for (int k = 0; k < 25; k++) begin
      tick();
      exp_g = ((k % 5) < MAX_HOLD) ? 4'(1 << ((k / 5) % N_REQ)) : 4'b0000;
      check($sformatf("rr_rotation_c%0d", k), 32'(grant), 32'(exp_g));
    end

    // Reset in the middle of a grant drops the write and restarts priority at 0.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0100; tick();
    check("midrst_grant_before", 32'(grant), 32'h4);
    wr_en = 4'b0100; wr_data = 32'h005A_0000; tick();
    check("midrst_q_before", 32'(q), 32'h5A);
    rst = 1'b1; req = 4'b1111; wr_en = 4'b0100; wr_data = 32'h0011_0000; tick();
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_q", 32'(q), 32'h0);
    rst = 1'b0; wr_en = '0; tick();
    check("midrst_first_grant", 32'(grant), 32'h1);

    // Holder 1 releases early; requester 3 follows after one idle cycle.
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0010; tick();
    check("early_rel_g1", 32'(grant), 32'h2);
    req = 4'b1010; tick();
    check("early_rel_g2", 32'(grant), 32'h2);
    req = 4'b1000; tick();
    check("early_rel_gap", 32'(grant), 32'h0);
    tick();
    check("early_rel_next", 32'(grant), 32'h8);

    // Randomized traffic against the model.
    rst = 1'b1; req = '0; wr_en = '0;
    model_step(); tick();
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 149) == 0);
      req     = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      wr_en   = 4'($urandom);
      wr_data = 32'($urandom);
      model_step();
      tick();
      exp_g = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
      check($sformatf("rand_c%0d_grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("rand_c%0d_q", c), 32'(q), 32'(m_q));
      check($sformatf("rand_c%0d_busy", c), 32'(busy), 32'(m_holder >= 0));
      check($sformatf("rand_c%0d_onehot", c), 32'($countones(grant) <= 1), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
